// File: rtl/div_ctrl.sv
// Sequencing controller for an external pipelined unsigned divider: sign handling, HI/LO ownership.
// Result and done arrive DIV_LATENCY+2 edges after acceptance; busy holds off requests, ignored starts have no effect.
module div_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int BITS        = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] rs,
    input  logic [BITS-1:0] rt,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] lo,
    output logic [BITS-1:0] div_dividend,
    output logic [BITS-1:0] div_divisor,
    input  logic [BITS-1:0] div_quotient,
    input  logic [BITS-1:0] div_remainder
);
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;
    localparam int CW = 6;
    localparam logic [CW-1:0] LAT = CW'(DIV_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, FIXUP, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            q_neg;
    logic            r_neg;
    logic [BITS-1:0] q_cap;
    logic [BITS-1:0] r_cap;

    logic            is_signed;
    logic [BITS-1:0] rs_mag;
    logic [BITS-1:0] rt_mag;

    // abs of the most negative value wraps to itself and is then read as unsigned
    assign is_signed = (op == OP_DIV);
    assign rs_mag    = (is_signed && rs[BITS-1]) ? -rs : rs;
    assign rt_mag    = (is_signed && rt[BITS-1]) ? -rt : rt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            q_cap        <= '0;
            r_cap        <= '0;
            hi           <= '0;
            lo           <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        case (op)
                            OP_MTHI: hi <= rs;
                            OP_MTLO: lo <= rs;
                            default: begin
                                if (rt == '0) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    div_zero <= 1'b1;
                                end else begin
                                    div_dividend <= rs_mag;
                                    div_divisor  <= rt_mag;
                                    q_neg        <= is_signed & (rs[BITS-1] ^ rt[BITS-1]);
                                    r_neg        <= is_signed & rs[BITS-1];
                                    counter      <= LAT;
                                    busy         <= 1'b1;
                                    state        <= WAIT;
                                end
                            end
                        endcase
                    end
                end
                WAIT: begin
                    // counter reaches zero exactly when the divider output reflects the held inputs
                    if (counter == '0) begin
                        q_cap <= div_quotient;
                        r_cap <= div_remainder;
                        state <= FIXUP;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                FIXUP: begin
                    lo    <= q_neg ? -q_cap : q_cap;
                    hi    <= r_neg ? -r_cap : r_cap;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: two instances (latency 0 and 32) driven in lockstep, each with its own divider and reference model.
module tb_div_ctrl;
    localparam int BITS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [BITS-1:0] rs = '0;
    logic [BITS-1:0] rt = '0;

    logic [1:0] busy_w, done_w, dz_w;
    logic [1:0][BITS-1:0] hi_w, lo_w, dvd_w, dvs_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] quo_of(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] rem_of(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x);
        longint v;
        v = $signed(x);
        return (v < 0) ? 32'(-v) : 32'(v);
    endfunction

    function automatic logic [31:0] sdiv_q(input logic [31:0] x, input logic [31:0] y);
        longint a, b;
        a = $signed(x);
        b = $signed(y);
        return 32'(a / b);
    endfunction

    function automatic logic [31:0] sdiv_r(input logic [31:0] x, input logic [31:0] y);
        longint a, b;
        a = $signed(x);
        b = $signed(y);
        return 32'(a % b);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int LAT = (g == 0) ? 0 : 32;
        logic [31:0] quo, rem;

        if (LAT == 0) begin : comb_div
            assign quo = quo_of(dvd_w[g], dvs_w[g]);
            assign rem = rem_of(dvd_w[g], dvs_w[g]);
        end else begin : pipe_div
            logic [31:0] pd [LAT];
            logic [31:0] ps [LAT];
            always @(posedge clk) begin
                pd[0] <= dvd_w[g];
                ps[0] <= dvs_w[g];
                for (int i = 1; i < LAT; i++) begin
                    pd[i] <= pd[i-1];
                    ps[i] <= ps[i-1];
                end
            end
            assign quo = quo_of(pd[LAT-1], ps[LAT-1]);
            assign rem = rem_of(pd[LAT-1], ps[LAT-1]);
        end

        div_ctrl #(.DIV_LATENCY(LAT), .BITS(BITS)) dut (
            .clock(clk), .reset(rst), .start(start), .op(op), .rs(rs), .rt(rt),
            .busy(busy_w[g]), .done(done_w[g]), .div_zero(dz_w[g]),
            .hi(hi_w[g]), .lo(lo_w[g]),
            .div_dividend(dvd_w[g]), .div_divisor(dvs_w[g]),
            .div_quotient(quo), .div_remainder(rem)
        );

        // Reference: a divide occupies LAT+2 edges, result computed arithmetically at acceptance
        int left;
        logic m_done, m_dz;
        logic [31:0] m_hi, m_lo, m_dvd, m_dvs, res_hi, res_lo;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                left <= 0;
                m_done <= 1'b0; m_dz <= 1'b0;
                m_hi <= '0; m_lo <= '0; m_dvd <= '0; m_dvs <= '0;
                res_hi <= '0; res_lo <= '0;
            end else begin
                m_done <= 1'b0;
                m_dz <= 1'b0;
                if (left > 0) begin
                    left <= left - 1;
                    if (left == 1) begin
                        m_hi <= res_hi;
                        m_lo <= res_lo;
                        m_done <= 1'b1;
                    end
                end else if (start) begin
                    if (op == 2'b10) m_hi <= rs;
                    else if (op == 2'b11) m_lo <= rs;
                    else if (rt == 0) begin
                        m_done <= 1'b1;
                        m_dz <= 1'b1;
                    end else begin
                        left <= LAT + 2;
                        if (op == 2'b01) begin
                            m_dvd <= mag(rs);  m_dvs <= mag(rt);
                            res_lo <= sdiv_q(rs, rt); res_hi <= sdiv_r(rs, rt);
                        end else begin
                            m_dvd <= rs;  m_dvs <= rt;
                            res_lo <= rs / rt; res_hi <= rs % rt;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("i0 busy", 32'(busy_w[0]), 32'(gi[0].left > 0));
        chk("i0 done", 32'(done_w[0]), 32'(gi[0].m_done));
        chk("i0 div_zero", 32'(dz_w[0]), 32'(gi[0].m_dz));
        chk("i0 hi", hi_w[0], gi[0].m_hi);
        chk("i0 lo", lo_w[0], gi[0].m_lo);
        chk("i0 dividend", dvd_w[0], gi[0].m_dvd);
        chk("i0 divisor", dvs_w[0], gi[0].m_dvs);
        chk("i1 busy", 32'(busy_w[1]), 32'(gi[1].left > 0));
        chk("i1 done", 32'(done_w[1]), 32'(gi[1].m_done));
        chk("i1 div_zero", 32'(dz_w[1]), 32'(gi[1].m_dz));
        chk("i1 hi", hi_w[1], gi[1].m_hi);
        chk("i1 lo", lo_w[1], gi[1].m_lo);
        chk("i1 dividend", dvd_w[1], gi[1].m_dvd);
        chk("i1 divisor", dvs_w[1], gi[1].m_dvs);
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_w != 2'b00 && n < 100) begin
            step();
            n++;
        end
        if (busy_w != 2'b00) begin
            checks++; errors++;
            $display("FAIL idle timeout busy=%b", busy_w);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs = a; rt = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done1(output int k);
        k = 0;
        while (!done_w[1] && k < 100) begin
            step();
            k++;
        end
        if (!done_w[1]) begin
            checks++; errors++;
            $display("FAIL done timeout on latency-32 instance");
        end
    endtask

    task automatic run_both(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int l0, output int l1);
        wait_idle();
        issue(o, a, b);
        l0 = -1;
        l1 = -1;
        for (int k = 0; k <= 80; k++) begin
            if (l0 < 0 && done_w[0]) l0 = k;
            if (l1 < 0 && done_w[1]) l1 = k;
            if (l0 >= 0 && l1 >= 0) break;
            step();
        end
        if (l0 < 0 || l1 < 0) begin
            checks++; errors++;
            $display("FAIL done timeout l0=%0d l1=%0d", l0, l1);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int l0, l1, k;
        @(posedge clk); #1;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", 32'(busy_w[i]), 32'd0);
            chk("reset hi", hi_w[i], 32'd0);
            chk("reset lo", lo_w[i], 32'd0);
        end
        rst = 1'b0;
        step();

        // reset while the latency-32 divide is in WAIT
        issue(2'b00, 32'd100, 32'd7);
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("midwait busy", 32'(busy_w[1]), 32'd0);
        chk("midwait hi", hi_w[1], 32'd0);
        chk("midwait lo", lo_w[1], 32'd0);
        step();
        rst = 1'b0;
        step();
        run_both(2'b00, 32'd100, 32'd7, l0, l1);
        chk("lat0 100/7", 32'(l0), 32'd2);
        chk("lat32 100/7", 32'(l1), 32'd34);
        chk("100/7 lo", lo_w[1], 32'd14);
        chk("100/7 hi", hi_w[1], 32'd2);

        run_both(2'b01, 32'hFFFF_FFF9, 32'd2, l0, l1);
        chk("-7/2 lo", lo_w[1], 32'hFFFF_FFFD);
        chk("-7/2 hi", hi_w[1], 32'hFFFF_FFFF);
        run_both(2'b01, 32'd7, 32'hFFFF_FFFE, l0, l1);
        chk("7/-2 lo", lo_w[0], 32'hFFFF_FFFD);
        chk("7/-2 hi", hi_w[0], 32'd1);
        run_both(2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFE, l0, l1);
        chk("-7/-2 lo", lo_w[1], 32'd3);
        chk("-7/-2 hi", hi_w[1], 32'hFFFF_FFFF);

        // divide by zero leaves HI/LO alone
        wait_idle();
        issue(2'b10, 32'h0000_AAAA, 32'd0);
        issue(2'b11, 32'h0000_5555, 32'd0);
        issue(2'b01, 32'd5, 32'd0);
        chk("dz done", 32'(done_w[1]), 32'd1);
        chk("dz flag", 32'(dz_w[1]), 32'd1);
        chk("dz busy", 32'(busy_w[1]), 32'd0);
        chk("dz hi", hi_w[1], 32'h0000_AAAA);
        chk("dz lo", lo_w[1], 32'h0000_5555);
        step();

        run_both(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, l0, l1);
        chk("ovf lo", lo_w[1], 32'h8000_0000);
        chk("ovf hi", hi_w[1], 32'd0);
        chk("ovf div_zero", 32'(dz_w[1]), 32'd0);

        // start during WAIT ignored; start in DONE accepted
        wait_idle();
        issue(2'b00, 32'd10, 32'd3);
        repeat (3) step();
        issue(2'b00, 32'd99, 32'd9);
        wait_done1(k);
        chk("ignored start latency", 32'(k), 32'd30);
        chk("10/3 lo", lo_w[1], 32'd3);
        chk("10/3 hi", hi_w[1], 32'd1);
        issue(2'b00, 32'd99, 32'd9);
        wait_done1(k);
        chk("done-cycle start latency", 32'(k), 32'd34);
        chk("99/9 lo", lo_w[1], 32'd11);
        chk("99/9 hi", hi_w[1], 32'd0);

        run_both(2'b00, 32'hFFFF_FFFF, 32'd1, l0, l1);
        chk("sweep lat0", 32'(l0), 32'd2);
        chk("sweep lat32", 32'(l1), 32'd34);
        chk("sweep lo0", lo_w[0], 32'hFFFF_FFFF);
        chk("sweep hi0", hi_w[0], 32'd0);
        chk("sweep lo32", lo_w[1], 32'hFFFF_FFFF);
        chk("sweep hi32", hi_w[1], 32'd0);

        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 2) == 0);
            op = 2'($urandom_range(0, 3));
            rs = pick();
            rt = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
            rst = (n == 300);
            step();
        end
        start = 1'b0;
        rst = 1'b0;
        wait_idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
